multi_operand_accum: RTL
========================

MULTI_OPERAND_ACCUM -- requirements
Module: multi_operand_accum

Interface
REQ-001 SHALL have parameter N, default 4, meaning the operand and sum width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, meaning the operand-counter width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, meaning an operand is offered.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts the offered operand.
REQ-007 SHALL have port in_data, input, N, the operand value.
REQ-008 SHALL have port in_cin, input, 1, the carry-in added together with the operand.
REQ-009 SHALL have port in_last, input, 1, marking the final operand of a group.
REQ-010 SHALL have port out_valid, output, 1, meaning a group result is presented.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-012 SHALL have port out_sum, output, N, the accumulated group sum.
REQ-013 SHALL have port out_cout, output, 1, a sticky flag set by any carry out of bit N-1 during the group.
REQ-014 SHALL have port out_count, output, CNT_W, the number of operands accepted in the group.

Function
REQ-015 SHALL implement a state machine with exactly three states: IDLE, ACCUM and HOLD.
REQ-016 SHALL accept an operand on a rising edge where in_valid=1 and in_ready=1.
REQ-017 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in HOLD.
REQ-018 SHALL, on each accept, update acc <= (acc + in_data + in_cin) mod 2^N, starting from acc=0 at the start of a group.
REQ-019 SHALL, on each accept, set the sticky cout flag if the (N+1)-bit sum of that step has bit N set.
REQ-020 SHALL, on each accept, increment the operand counter, saturating at 2^CNT_W-1 with no wrap.
REQ-021 SHALL transition IDLE->ACCUM on an accept with in_last=0, and IDLE->HOLD on an accept with in_last=1.
REQ-022 SHALL transition ACCUM->HOLD on an accept with in_last=1, and remain in ACCUM otherwise.
REQ-023 SHALL drive out_valid=1 only in HOLD, so the result is valid the cycle after the in_last accept (latency 1).
REQ-024 SHALL hold out_sum, out_cout and out_count stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, on a rising edge where out_valid=1 and out_ready=1, clear acc, the cout flag and the counter, and go to IDLE.
REQ-026 SHALL not permit a result handshake and an input accept in the same cycle, since in_ready=0 in HOLD.
REQ-027 SHALL ignore in_data, in_cin and in_last whenever in_valid=0.
REQ-028 SHALL drive out_sum, out_cout and out_count from registers only, with no combinational path from the inputs.

Reset
REQ-029 SHALL, while rst_n=0, immediately force state=IDLE, acc=0, cout flag=0, counter=0, out_valid=0 and in_ready=0.
REQ-030 SHALL drive in_ready=1 from the first rising edge of clk after rst_n deasserts.
REQ-031 SHALL, if rst_n asserts mid-group, discard the partial group with no result emitted.

Configuration
REQ-032 SHALL, when macro ACCUM_SAT_EN is defined, compute each accept step as an (N+1)-bit sum and load acc with all ones (2^N-1) whenever bit N is set, otherwise with the low N bits; once saturated, acc SHALL stay at all ones for the rest of the group.
REQ-033 SHALL, when ACCUM_SAT_EN is not defined, wrap acc modulo 2^N.
REQ-034 SHALL set out_cout identically in both configurations.

Verification
REQ-035 Bench SHALL cover, with N=4 and no saturation: accept 1101 (cin 0), then 1011 (cin 0, last) -> out_sum=1000, out_cout=1, out_count=2.
REQ-036 Bench SHALL cover: accept 0110, then 1001 (last), with cin 0 on both -> out_sum=1111, out_cout=0, out_count=2.
REQ-037 Bench SHALL cover: a single operand 0101 with cin=1 and last=1 -> out_valid=1 on the next cycle, out_sum=0110, out_count=1.
REQ-038 Bench SHALL cover, with ACCUM_SAT_EN defined: accept 1111 (cin 1), then 1111 (cin 0, last) -> out_sum=1111, out_cout=1.
REQ-039 Bench SHALL cover backpressure: out_ready=0 for 5 cycles -> result unchanged and in_ready=0 throughout; out_ready=1 -> next cycle out_valid=0 and in_ready=1.
REQ-040 Bench SHALL cover reset mid-group: after 2 accepts, pulse rst_n low -> out_valid=0 and the next group result counts only its own operands.

Source files
------------

// File: rtl/multi_operand_accum.sv
// Multi-operand accumulator: sums a group of N-bit operands (plus carry-ins) ended by in_last, then holds the result until taken.
// Latency 1 from the in_last accept to out_valid; in_ready drops while a result waits. Define ACCUM_SAT_EN to saturate acc instead of wrapping.
module multi_operand_accum #(
   parameter int N     = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   input  logic             in_cin,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_sum,
   output logic             out_cout,
   output logic [CNT_W-1:0] out_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     acc_q, acc_d;
   logic             cout_q, cout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             live_q, live_d;
   logic             accept;
   logic             release_res;
   logic [N:0]       step_sum;

   assign accept      = in_valid && in_ready;
   assign release_res = out_valid && out_ready;
   assign step_sum    = {1'b0, acc_q} + {1'b0, in_data} + {{N{1'b0}}, in_cin};
   assign live_d      = 1'b1;

   // live_q keeps in_ready low until the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
         live_q  <= live_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = in_last ? HOLD : ACCUM;
         ACCUM:   if (accept && in_last) state_d = HOLD;
         HOLD:    if (release_res) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE, ACCUM: in_ready  = live_q;
         HOLD:        out_valid = 1'b1;
         default:     ;
      endcase
   end

   always_comb begin
      acc_d  = acc_q;
      cout_d = cout_q;
      cnt_d  = cnt_q;
      if (release_res) begin
         acc_d  = '0;
         cout_d = 1'b0;
         cnt_d  = '0;
      end else if (accept) begin
`ifdef ACCUM_SAT_EN
         acc_d = step_sum[N] ? {N{1'b1}} : step_sum[N-1:0];
`else
         acc_d = step_sum[N-1:0];
`endif
         cout_d = cout_q | step_sum[N];
         cnt_d  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
      end
   end

   assign out_sum   = acc_q;
   assign out_cout  = cout_q;
   assign out_count = cnt_q;

endmodule
